// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus: read FSM states, default bus timing
// (also used by the writer) and status-byte bit positions.
package lcd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StEnHi,
    StHold,
    StGap
  } lcd_rd_state_t;

  // Default timing in 50 MHz clock cycles
  localparam int unsigned LCD_T_SETUP   = 3;
  localparam int unsigned LCD_T_EN_HIGH = 25;
  localparam int unsigned LCD_T_HOLD    = 2;
  localparam int unsigned LCD_T_GAP     = 25;
  localparam int unsigned LCD_MAX_POLL  = 1000;

  localparam int unsigned BF_BIT = 7;
  localparam int unsigned AC_MSB = 6;

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero, so loading N-1
// gives a phase that lasts exactly N cycles.
module lcd_cycle_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             done
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// Read-side controller for the HD44780 LCD bus: single status/data reads with RW=1,
// plus an optional busy-flag poll loop bounded by MAX_POLL.
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP   = LCD_T_SETUP,
  parameter int unsigned T_EN_HIGH = LCD_T_EN_HIGH,
  parameter int unsigned T_HOLD    = LCD_T_HOLD,
  parameter int unsigned T_GAP     = LCD_T_GAP,
  parameter int unsigned MAX_POLL  = LCD_MAX_POLL
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req,
  input  logic       i_rs,
  input  logic       i_poll,
  output logic       o_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_timeout,
  output logic       o_bus_owned,
  input  logic [7:0] i_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en
);

  if (T_SETUP < 1 || T_SETUP > 256) begin : g_bad_setup
    $error("T_SETUP must be in 1..256");
  end
  if (T_EN_HIGH < 1 || T_EN_HIGH > 256) begin : g_bad_en_high
    $error("T_EN_HIGH must be in 1..256");
  end
  if (T_HOLD < 1 || T_HOLD > 256) begin : g_bad_hold
    $error("T_HOLD must be in 1..256");
  end
  if (T_GAP < 1 || T_GAP > 256) begin : g_bad_gap
    $error("T_GAP must be in 1..256");
  end
  if (MAX_POLL < 1 || MAX_POLL > 65535) begin : g_bad_max_poll
    $error("MAX_POLL must be in 1..65535");
  end

  localparam logic [7:0]  SetupLd = 8'(T_SETUP - 1);
  localparam logic [7:0]  EnLd    = 8'(T_EN_HIGH - 1);
  localparam logic [7:0]  HoldLd  = 8'(T_HOLD - 1);
  localparam logic [7:0]  GapLd   = 8'(T_GAP - 1);
  localparam logic [15:0] MaxPoll = 16'(MAX_POLL);

  lcd_rd_state_t state_q, state_d;
  logic        rs_q, rs_d;
  logic        poll_q, poll_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;
  logic        ready_q, owned_q, en_q;
  logic        tmr_load, tmr_done;
  logic [7:0]  tmr_val;

  lcd_cycle_timer #(
    .Width(8)
  ) u_timer (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    rs_d       = rs_q;
    poll_d     = poll_q;
    poll_cnt_d = poll_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    unique case (state_q)
      StIdle: begin
        if (i_req) begin
          rs_d       = i_rs;
          poll_d     = i_poll & ~i_rs;
          poll_cnt_d = 16'd1;
          state_d    = StSetup;
          tmr_load   = 1'b1;
          tmr_val    = SetupLd;
        end
      end
      StSetup: begin
        if (tmr_done) begin
          state_d  = StEnHi;
          tmr_load = 1'b1;
          tmr_val  = EnLd;
        end
      end
      StEnHi: begin
        if (tmr_done) begin
          data_d   = i_lcd_data;
          state_d  = StHold;
          tmr_load = 1'b1;
          tmr_val  = HoldLd;
        end
      end
      StHold: begin
        if (tmr_done) begin
          state_d  = StGap;
          tmr_load = 1'b1;
          tmr_val  = GapLd;
        end
      end
      StGap: begin
        if (tmr_done) begin
          if (poll_q && data_q[BF_BIT] && (poll_cnt_q < MaxPoll)) begin
            poll_cnt_d = poll_cnt_q + 16'd1;
            state_d    = StSetup;
            tmr_load   = 1'b1;
            tmr_val    = SetupLd;
          end else begin
            valid_d   = 1'b1;
            timeout_d = poll_q & data_q[BF_BIT];
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus-facing outputs are decoded from the next state and registered so EN cannot glitch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      rs_q       <= 1'b0;
      poll_q     <= 1'b0;
      poll_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      ready_q    <= 1'b1;
      owned_q    <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_q       <= rs_d;
      poll_q     <= poll_d;
      poll_cnt_q <= poll_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      ready_q    <= (state_d == StIdle);
      owned_q    <= (state_d != StIdle);
      en_q       <= (state_d == StEnHi);
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_timeout   = timeout_q;
  assign o_bus_owned = owned_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = owned_q;
  assign o_lcd_en    = en_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Bench for lcd_bus_reader: table of read requests with a scoreboard of expected
// results, an LCD pad model that answers per EN pulse, and reset/abort sequences.
module tb_lcd_bus_reader;

  localparam int unsigned CycPerRead = 55;
  localparam int unsigned EnHigh     = 25;
  localparam int unsigned Setup      = 3;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_req = 1'b0;
  logic       i_rs = 1'b0;
  logic       i_poll = 1'b0;
  logic [7:0] i_lcd_data;
  logic       o_ready, o_valid, o_timeout, o_bus_owned;
  logic [7:0] o_data;
  logic       o_lcd_rs, o_lcd_rw, o_lcd_en;

  always #5 i_clk = ~i_clk;

  lcd_bus_reader #(
    .MAX_POLL(5)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req),
    .i_rs       (i_rs),
    .i_poll     (i_poll),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_timeout  (o_timeout),
    .o_bus_owned(o_bus_owned),
    .i_lcd_data (i_lcd_data),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_en   (o_lcd_en)
  );

  typedef struct {
    logic [7:0] data;
    logic       timeout;
    int         due;
  } exp_t;

  typedef struct {
    logic       rs;
    logic       poll;
    logic [7:0] pad0;
    logic [7:0] pad1;
    logic [7:0] pad2;
    logic [7:0] pad3;
    int         npad;
    logic [7:0] exp_data;
    logic       exp_to;
    int         pulses;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[6];
  logic [7:0] pad[4];
  int         npad = 1;
  int         pad_k;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rises = 0;
  int         falls = 0;
  int         rise_base = 0;
  int         fall_base = 0;
  int         en_run = 0;
  int         pre = 0;
  logic       en_prev = 1'b0;
  logic       cur_rs = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Pad answers with the next scripted byte after each EN fall, sticking on the last one.
  always_comb begin
    pad_k = falls - fall_base;
    if (pad_k > npad - 1) pad_k = npad - 1;
    if (pad_k < 0) pad_k = 0;
    i_lcd_data = pad[pad_k];
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      en_prev <= 1'b0;
      en_run  <= 0;
      pre     <= 0;
    end else begin
      if (o_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", 32'(o_valid), 0);
        end else begin
          chk("data", 32'(o_data), 32'(sb[0].data));
          chk("timeout", 32'(o_timeout), 32'(sb[0].timeout));
          chk("latency", cyc, sb[0].due);
          chk("ready_at_valid", 32'(o_ready), 1);
          sb.delete(0);
        end
      end
      if (o_lcd_en && !en_prev) begin
        if (rises == rise_base) chk("setup_cycles", pre, Setup);
        chk("rs_at_en", 32'(o_lcd_rs), 32'(cur_rs));
        chk("rw_at_en", 32'(o_lcd_rw), 1);
        chk("owned_at_en", 32'(o_bus_owned), 1);
        rises <= rises + 1;
      end
      if (o_lcd_en) begin
        en_run <= en_run + 1;
      end else begin
        en_run <= 0;
        if (en_prev) begin
          chk("en_high_len", en_run, EnHigh);
          falls <= falls + 1;
        end
      end
      pre     <= (o_lcd_rw && !o_lcd_en) ? pre + 1 : 0;
      en_prev <= o_lcd_en;
    end
  end

  task automatic run_vec(input vec_t v, input bit noisy);
    bit done;
    int acc;
    pad[0] = v.pad0;
    pad[1] = v.pad1;
    pad[2] = v.pad2;
    pad[3] = v.pad3;
    npad = v.npad;
    @(negedge i_clk);
    fall_base = falls;
    rise_base = rises;
    cur_rs = v.rs;
    chk("ready_before_req", 32'(o_ready), 1);
    i_req  = 1'b1;
    i_rs   = v.rs;
    i_poll = v.poll;
    @(posedge i_clk);
    #1;
    acc = cyc;
    sb.push_back('{data: v.exp_data, timeout: v.exp_to, due: acc + int'(CycPerRead) * v.pulses});
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge i_clk);
      // Inputs flip after accept; the latched request must not change.
      i_rs   = ~v.rs;
      i_poll = ~v.poll;
      i_req  = noisy && o_lcd_en;
      if (o_valid) done = 1'b1;
      else if (noisy) chk("ready_while_busy", 32'(o_ready), 0);
    end
    i_req = 1'b0;
    if (!done) chk("valid_timeout", 0, 1);
    chk("en_pulses", rises - rise_base, v.pulses);
  endtask

  initial begin
    bit seen;
    vecs[0] = '{1'b0, 1'b0, 8'h25, 8'h00, 8'h00, 8'h00, 1, 8'h25, 1'b0, 1};
    vecs[1] = '{1'b1, 1'b1, 8'h41, 8'h00, 8'h00, 8'h00, 1, 8'h41, 1'b0, 1};
    vecs[2] = '{1'b0, 1'b1, 8'h80, 8'h80, 8'h80, 8'h0C, 4, 8'h0C, 1'b0, 4};
    vecs[3] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 8'hFF, 1'b1, 5};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'h00, 1'b0, 1};
    vecs[5] = '{1'b1, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 1, 8'hA5, 1'b0, 1};
    pad[0] = 8'h00;
    pad[1] = 8'h00;
    pad[2] = 8'h00;
    pad[3] = 8'h00;

    repeat (3) @(negedge i_clk);
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_timeout", 32'(o_timeout), 0);
    chk("rst_owned", 32'(o_bus_owned), 0);
    chk("rst_rs", 32'(o_lcd_rs), 0);
    chk("rst_rw", 32'(o_lcd_rw), 0);
    chk("rst_en", 32'(o_lcd_en), 0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0);
    run_vec(vecs[0], 1'b1);

    // Abort a status read 10 cycles into EN high; nothing is pushed, so any o_valid is spurious.
    pad[0] = 8'h25;
    npad = 1;
    @(negedge i_clk);
    fall_base = falls;
    rise_base = rises;
    cur_rs = 1'b0;
    i_req  = 1'b1;
    i_rs   = 1'b0;
    i_poll = 1'b0;
    @(negedge i_clk);
    i_req = 1'b0;
    for (int c = 0; c < 100 && !o_lcd_en; c++) @(negedge i_clk);
    chk("abort_en_reached", 32'(o_lcd_en), 1);
    repeat (10) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("abort_en", 32'(o_lcd_en), 0);
    chk("abort_owned", 32'(o_bus_owned), 0);
    chk("abort_rw", 32'(o_lcd_rw), 0);
    chk("abort_ready", 32'(o_ready), 1);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge i_clk);
      if (o_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 32'(seen), 0);

    run_vec(vecs[2], 1'b0);
    run_vec(vecs[5], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_reader.md
Name: lcd_bus_reader

Overview:
- Read-side controller for the HD44780-compatible character LCD on the board's 8-bit LCD bus, complementing the existing write-only LCD path.
- Runs single read cycles with RW=1: a status read (RS=0, returns busy flag plus address counter) or a data read (RS=1, returns a DDRAM/CGRAM byte).
- Optional poll mode repeats status reads until the busy flag clears or a poll limit is reached.
- Sits beside the LCD writer; top level muxes RS/RW/EN and disables the data pad driver whenever o_bus_owned=1.

Parameters:
- T_SETUP, 3, cycles RS/RW stable before EN rises (60 ns at 50 MHz).
- T_EN_HIGH, 25, cycles EN held high (500 ns); data sampled on last EN-high cycle.
- T_HOLD, 2, cycles RS/RW held after EN falls.
- T_GAP, 25, recovery cycles before next EN rise or IDLE (enforces >=1 us EN cycle).
- MAX_POLL, 1000, maximum status reads in one poll request (1..65535).

Ports:
- i_clk  in  1  system clock, 50 MHz
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  1  request strobe; accepted only when o_ready=1
- i_rs  in  1  0 = status read, 1 = data read; sampled at accept
- i_poll  in  1  1 = repeat status reads until BF=0; ignored when i_rs=1; sampled at accept
- o_ready  out  1  high only in IDLE
- o_valid  out  1  one-cycle pulse: o_data/o_timeout valid
- o_data  out  8  last sampled byte; for status reads bit7=BF, bits6:0=AC
- o_timeout  out  1  valid with o_valid; 1 = poll ended with BF still 1
- o_bus_owned  out  1  high SETUP through GAP; top must tri-state its data driver
- i_lcd_data  in  8  LCD_DATA pad input
- o_lcd_rs  out  1  LCD RS
- o_lcd_rw  out  1  LCD RW
- o_lcd_en  out  1  LCD EN

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_ready=1; o_valid=0; o_data=8'h00; o_timeout=0; o_bus_owned=0; o_lcd_rs=0; o_lcd_rw=0; o_lcd_en=0; counters cleared.
- States: IDLE, SETUP, EN_HI, HOLD, GAP. One 8-bit cycle counter and one 16-bit poll counter.
- IDLE: o_lcd_rw=0, o_lcd_en=0, o_bus_owned=0. On i_req=1, latch rs_q=i_rs and poll_q=i_poll & ~i_rs, set poll count to 1, then go to SETUP. o_ready drops on the next cycle.
- SETUP: o_lcd_rw=1, o_lcd_rs=rs_q, o_bus_owned=1, en=0. After T_SETUP cycles go to EN_HI.
- EN_HI: en=1 for exactly T_EN_HIGH cycles. On the last cycle, register i_lcd_data into o_data. Then go to HOLD.
- HOLD: en=0, RS/RW unchanged for T_HOLD cycles, then go to GAP.
- GAP: en=0, rw=1, bus still owned for T_GAP cycles. Then:
  - poll_q=1, o_data[7]=1 and poll count < MAX_POLL: increment poll count and return to SETUP.
  - Otherwise: pulse o_valid for one cycle, set o_timeout = poll_q & o_data[7], and go to IDLE.
- The o_valid pulse occurs on the same edge that enters IDLE, so o_ready=1 in the o_valid cycle.
- Latency for a single read, accept edge to o_valid edge: T_SETUP+T_EN_HIGH+T_HOLD+T_GAP cycles (55 at defaults).
- Each poll iteration adds the same count.
- i_req outside IDLE is ignored; there is no queue.
- i_rs/i_poll changes after accept have no effect.
- o_data holds its value until the next sample; o_timeout holds until the next o_valid.
- Async reset mid-cycle forces EN low and releases the bus immediately. The aborted transfer produces no o_valid.
- EN never glitches: all LCD outputs are registered.
- Counter terminal compares use param-1. Every T_* must be >=1; elaborate-time assertion on each.

Decomposition:
- Shared package lcd_pkg:
  - state enum lcd_rd_state_t
  - default timing constants
  - status bit indices: BF_BIT=7, AC_MSB=6
  - the writer reuses the timing constants
- One natural sub-module, lcd_cycle_timer: a loadable down-counter with a done flag, instantiated once and reloaded per state.

Test Plan:
- Status read, pad drives 8'h25 during EN_HI, i_rs=0, i_poll=0 -> o_valid 55 cycles after accept, o_data=8'h25, o_timeout=0, EN high exactly 25 cycles, RW=1 from 3 cycles before EN rise to 2 after fall.
- Data read, pad = 8'h41, i_rs=1, i_poll=1 -> poll ignored: single cycle, o_lcd_rs=1 throughout, o_data=8'h41, o_valid after 55 cycles.
- Poll, pad returns 8'h80 for first 3 reads then 8'h0C -> 4 EN pulses, o_valid at 220 cycles, o_data=8'h0C, o_timeout=0.
- Poll with MAX_POLL=5, pad stuck 8'hFF -> exactly 5 EN pulses, o_valid with o_data=8'hFF, o_timeout=1.
- i_req pulses during EN_HI -> ignored, single o_valid; o_ready=0 from accept+1 until o_valid cycle.
- i_rst_n low 10 cycles into EN_HI -> o_lcd_en=0, o_bus_owned=0, o_lcd_rw=0 asynchronously, no o_valid; new request after release completes normally.
